// File: rtl/bank_sel_buf_pkg.sv
// Shared parameter header (param_define) and bank-select defaults.
// Address/data width macros are guarded so a project-wide header may override them.
`ifndef A_W
`define A_W 8
`endif
`ifndef D_W
`define D_W 32
`endif

package bank_sel_buf_pkg;
  localparam int NB_LOG2_DEF = 2;
  localparam int WB_LOG2_DEF = 2;

  function automatic int bank_aw(input int aw, input int nb_log2);
    return aw - nb_log2;
  endfunction
endpackage

// File: rtl/wbuf_fifo.sv
// In-order write buffer: stores {address, data}, tracks count, compares every valid entry to a probe address.
// Latency: push visible at head next cycle. Backpressure: caller must not push when count == depth.
module wbuf_fifo
  import bank_sel_buf_pkg::*;
#(
  parameter int A_W     = `A_W,
  parameter int D_W     = `D_W,
  parameter int WB_LOG2 = WB_LOG2_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push,
  input  logic [A_W-1:0]       push_adr,
  input  logic [D_W-1:0]       push_dat,
  input  logic                 pop,
  input  logic [A_W-1:0]       cmp_adr,
  output logic [A_W-1:0]       head_adr,
  output logic [D_W-1:0]       head_dat,
  output logic [WB_LOG2:0]     count,
  output logic [2**WB_LOG2-1:0] hit
);
  localparam int DEPTH = 2**WB_LOG2;

  logic [A_W-1:0]     adr_q [DEPTH];
  logic [D_W-1:0]     dat_q [DEPTH];
  logic [DEPTH-1:0]   vld_q;
  logic [WB_LOG2-1:0] wr_ptr;
  logic [WB_LOG2-1:0] rd_ptr;

  // Payload storage carries no reset; only the valid bits define occupancy.
  always_ff @(posedge clk) begin
    if (push) begin
      adr_q[wr_ptr] <= push_adr;
      dat_q[wr_ptr] <= push_dat;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      vld_q  <= '0;
    end else begin
      if (push) begin
        vld_q[wr_ptr] <= 1'b1;
        wr_ptr        <= wr_ptr + WB_LOG2'(1);
      end
      if (pop) begin
        vld_q[rd_ptr] <= 1'b0;
        rd_ptr        <= rd_ptr + WB_LOG2'(1);
      end
      count <= count + (WB_LOG2+1)'(push) - (WB_LOG2+1)'(pop);
    end
  end

  assign head_adr = adr_q[rd_ptr];
  assign head_dat = dat_q[rd_ptr];

  always_comb begin
    hit = '0;
    for (int i = 0; i < DEPTH; i++) begin
      hit[i] = vld_q[i] && (adr_q[i] == cmp_adr);
    end
  end
endmodule

// File: rtl/bank_sel_buf.sv
// Steers one read and one buffered write per cycle onto NB single-port banks; reads always win.
// Latency: reads and bypassed writes issue same cycle; W_READY drops when the buffer holds 2**WB_LOG2 entries.
module bank_sel_buf
  import bank_sel_buf_pkg::*;
#(
  parameter int A_W     = `A_W,
  parameter int D_W     = `D_W,
  parameter int NB_LOG2 = NB_LOG2_DEF,
  parameter int WB_LOG2 = WB_LOG2_DEF
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic                          RE,
  input  logic [A_W-1:0]                R_ADR,
  input  logic                          WE,
  input  logic [A_W-1:0]                W_ADR,
  input  logic [D_W-1:0]                W_DATA,
  output logic                          W_READY,
  output logic [2**NB_LOG2-1:0]         EN,
  output logic [2**NB_LOG2-1:0]         WEN,
  output logic [(2**NB_LOG2)*bank_aw(A_W, NB_LOG2)-1:0] A,
  output logic [(2**NB_LOG2)*D_W-1:0]   D,
  output logic [NB_LOG2-1:0]            R_SEL,
  output logic                          R_HAZ,
  output logic                          OVF
);
  localparam int NB    = 2**NB_LOG2;
  localparam int BA_W  = bank_aw(A_W, NB_LOG2);
  localparam int DEPTH = 2**WB_LOG2;

  logic [NB_LOG2-1:0] rb, wb, hb;
  logic [A_W-1:0]     head_adr;
  logic [D_W-1:0]     head_dat;
  logic [WB_LOG2:0]   count;
  logic [DEPTH-1:0]   hit;
  logic               empty, r_act, w_acc, bypass, push, drain;

  assign rb     = R_ADR[NB_LOG2-1:0];
  assign wb     = W_ADR[NB_LOG2-1:0];
  assign hb     = head_adr[NB_LOG2-1:0];
  assign empty  = (count == '0);
  assign W_READY = (count < (WB_LOG2+1)'(DEPTH));

  // All bank activity is suppressed while reset is held.
  assign r_act  = RE && !RST;
  assign w_acc  = WE && W_READY && !RST;
  assign bypass = w_acc && empty && !(r_act && (wb == rb));
  assign push   = w_acc && !bypass;
  assign drain  = !empty && !RST && !(r_act && (hb == rb));
  assign R_HAZ  = RE && (|hit);

  wbuf_fifo #(.A_W(A_W), .D_W(D_W), .WB_LOG2(WB_LOG2)) u_fifo (
    .clk      (CLK),
    .rst      (RST),
    .push     (push),
    .push_adr (W_ADR),
    .push_dat (W_DATA),
    .pop      (drain),
    .cmp_adr  (R_ADR),
    .head_adr (head_adr),
    .head_dat (head_dat),
    .count    (count),
    .hit      (hit)
  );

  always_comb begin
    EN  = '0;
    WEN = '0;
    A   = '0;
    D   = '0;
    if (r_act) begin
      EN[rb]                = 1'b1;
      A[rb*BA_W +: BA_W]    = R_ADR[A_W-1:NB_LOG2];
    end
    // bypass needs an empty buffer and drain a non-empty one, so they never collide.
    if (bypass) begin
      EN[wb]                = 1'b1;
      WEN[wb]               = 1'b1;
      A[wb*BA_W +: BA_W]    = W_ADR[A_W-1:NB_LOG2];
      D[wb*D_W +: D_W]      = W_DATA;
    end
    if (drain) begin
      EN[hb]                = 1'b1;
      WEN[hb]               = 1'b1;
      A[hb*BA_W +: BA_W]    = head_adr[A_W-1:NB_LOG2];
      D[hb*D_W +: D_W]      = head_dat;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      R_SEL <= '0;
      OVF   <= 1'b0;
    end else begin
      if (RE) R_SEL <= rb;
      if (WE && !W_READY) OVF <= 1'b1;
    end
  end

  logic unused_nb;
  assign unused_nb = (NB == 0);
endmodule

// File: tb/tb_bank_sel_buf.sv
// Directed bench for bank_sel_buf: bypass, conflict, ordering, full/overflow, hazard, reset mid-drain.
module tb_bank_sel_buf;
  localparam int A_W  = 8;
  localparam int D_W  = 32;
  localparam int NB   = 4;
  localparam int BA_W = 6;

  logic              CLK = 1'b0;
  logic              RST, RE, WE;
  logic [A_W-1:0]    R_ADR, W_ADR;
  logic [D_W-1:0]    W_DATA;
  logic              W_READY, R_HAZ, OVF;
  logic [NB-1:0]     EN, WEN;
  logic [NB*BA_W-1:0] A;
  logic [NB*D_W-1:0] D;
  logic [1:0]        R_SEL;

  int n_cmp = 0;
  int n_err = 0;

  bank_sel_buf #(.A_W(A_W), .D_W(D_W), .NB_LOG2(2), .WB_LOG2(2)) dut (
    .CLK(CLK), .RST(RST), .RE(RE), .R_ADR(R_ADR), .WE(WE), .W_ADR(W_ADR),
    .W_DATA(W_DATA), .W_READY(W_READY), .EN(EN), .WEN(WEN), .A(A), .D(D),
    .R_SEL(R_SEL), .R_HAZ(R_HAZ), .OVF(OVF)
  );

  always #5 CLK = ~CLK;

  function automatic logic [BA_W-1:0] a_of(input int k);
    return A[k*BA_W +: BA_W];
  endfunction

  function automatic logic [D_W-1:0] d_of(input int k);
    return D[k*D_W +: D_W];
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    RST = 1'b1; RE = 1'b0; WE = 1'b0; R_ADR = '0; W_ADR = '0; W_DATA = '0;
    #2;
    chk("rst_wready", W_READY, 1);
    chk("rst_ovf", OVF, 0);
    chk("rst_rsel", R_SEL, 0);
    chk("rst_en", EN, 0);
    chk("rst_count", dut.u_fifo.count, 0);
    step();
    RST = 1'b0;

    // no conflict: read bank0, write bank1 bypasses
    RE = 1; R_ADR = 8'h10; WE = 1; W_ADR = 8'h11; W_DATA = 32'hAAAA0001;
    #1;
    chk("nc_en", EN, 4'b0011);
    chk("nc_wen", WEN, 4'b0010);
    chk("nc_a0", a_of(0), 6'h04);
    chk("nc_a1", a_of(1), 6'h04);
    chk("nc_d1", d_of(1), 32'hAAAA0001);
    chk("nc_haz", R_HAZ, 0);
    step();
    chk("nc_count", dut.u_fifo.count, 0);
    chk("nc_rsel", R_SEL, 0);

    // conflict: both bank0, write buffered then drained
    R_ADR = 8'h04; W_ADR = 8'h08; W_DATA = 32'hBBBB0002;
    #1;
    chk("cf_en", EN, 4'b0001);
    chk("cf_wen", WEN, 4'b0000);
    chk("cf_a0", a_of(0), 6'h01);
    step();
    chk("cf_count1", dut.u_fifo.count, 1);
    RE = 0; WE = 0;
    #1;
    chk("cf_dr_en", EN, 4'b0001);
    chk("cf_dr_wen", WEN, 4'b0001);
    chk("cf_dr_a0", a_of(0), 6'h02);
    chk("cf_dr_d0", d_of(0), 32'hBBBB0002);
    step();
    chk("cf_count0", dut.u_fifo.count, 0);

    // R_SEL registers on a read and holds otherwise
    RE = 1; R_ADR = 8'h13;
    #1;
    chk("rs_en", EN, 4'b1000);
    chk("rs_a3", a_of(3), 6'h04);
    step();
    chk("rs_sel", R_SEL, 2'd3);
    RE = 0;
    step();
    chk("rs_hold", R_SEL, 2'd3);
    chk("rs_idle_en", EN, 4'b0000);

    // ordering: read held on bank0, three writes all enqueue
    RE = 1; R_ADR = 8'h00; WE = 1; W_ADR = 8'h00; W_DATA = 32'hC0;
    #1;
    chk("or_wen0", WEN, 4'b0000);
    step();
    chk("or_count1", dut.u_fifo.count, 1);
    W_ADR = 8'h01; W_DATA = 32'hC1;
    #1;
    chk("or_nobyp1_en", EN, 4'b0001);
    chk("or_nobyp1_wen", WEN, 4'b0000);
    step();
    chk("or_count2", dut.u_fifo.count, 2);
    W_ADR = 8'h02; W_DATA = 32'hC2;
    #1;
    chk("or_nobyp2_wen", WEN, 4'b0000);
    step();
    chk("or_count3", dut.u_fifo.count, 3);
    RE = 0; WE = 0;
    #1;
    chk("or_r0_wen", WEN, 4'b0001);
    chk("or_r0_a", a_of(0), 6'h00);
    chk("or_r0_d", d_of(0), 32'hC0);
    step();
    chk("or_r1_wen", WEN, 4'b0010);
    chk("or_r1_a", a_of(1), 6'h00);
    chk("or_r1_d", d_of(1), 32'hC1);
    step();
    chk("or_r2_wen", WEN, 4'b0100);
    chk("or_r2_en", EN, 4'b0100);
    chk("or_r2_d", d_of(2), 32'hC2);
    step();
    chk("or_count0", dut.u_fifo.count, 0);

    // hazard against a buffered write
    RE = 1; R_ADR = 8'h00; WE = 1; W_ADR = 8'h0C; W_DATA = 32'hD0C;
    step();
    chk("hz_count1", dut.u_fifo.count, 1);
    WE = 0; R_ADR = 8'h0C;
    #1;
    chk("hz_hit", R_HAZ, 1);
    chk("hz_hit_en", EN, 4'b0001);
    chk("hz_hit_wen", WEN, 4'b0000);
    step();
    R_ADR = 8'h0D;
    #1;
    chk("hz_miss", R_HAZ, 0);
    chk("hz_miss_en", EN, 4'b0011);
    chk("hz_miss_wen", WEN, 4'b0001);
    chk("hz_miss_a0", a_of(0), 6'h03);
    chk("hz_miss_a1", a_of(1), 6'h03);
    step();
    chk("hz_count0", dut.u_fifo.count, 0);
    chk("hz_rsel", R_SEL, 2'd1);

    // full / overflow: continuous read on bank0, five writes to bank0
    RE = 1; R_ADR = 8'h00;
    for (int i = 0; i < 5; i++) begin
      WE = 1; W_ADR = 8'(i * 4); W_DATA = 32'hE0 + 32'(i);
      #1;
      chk($sformatf("fl_wready%0d", i), W_READY, (i < 4) ? 1 : 0);
      step();
      chk($sformatf("fl_count%0d", i), dut.u_fifo.count, (i < 4) ? i + 1 : 4);
    end
    WE = 0;
    chk("fl_ovf", OVF, 1);
    chk("fl_wready_lo", W_READY, 0);
    step();
    chk("fl_ovf_sticky", OVF, 1);

    // reset mid-drain with three entries left
    RE = 0;
    #1;
    chk("rd_en", EN, 4'b0001);
    chk("rd_wen", WEN, 4'b0001);
    chk("rd_d0", d_of(0), 32'hE0);
    step();
    chk("rd_count3", dut.u_fifo.count, 3);
    chk("rd_ovf_still", OVF, 1);
    #2;
    RST = 1;
    #1;
    chk("rd_rst_count", dut.u_fifo.count, 0);
    chk("rd_rst_ovf", OVF, 0);
    chk("rd_rst_en", EN, 4'b0000);
    chk("rd_rst_wen", WEN, 4'b0000);
    chk("rd_rst_wready", W_READY, 1);
    step();
    chk("rd_held_en", EN, 4'b0000);
    RST = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("rd_post_wen%0d", i), WEN, 4'b0000);
      step();
    end
    chk("rd_post_count", dut.u_fifo.count, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/bank_sel_buf.md
BANK_SEL_BUF -- requirements
Module: bank_sel_buf

Interface
REQ-001 SHALL have parameter A_W, default `A_W, meaning total word-address width.
REQ-002 SHALL have parameter D_W, default 32, meaning write-data width.
REQ-003 SHALL have parameter NB_LOG2, default 2, meaning bank-select bits; NB = 2**NB_LOG2 single-port banks; BA_W = A_W-NB_LOG2.
REQ-004 SHALL have parameter WB_LOG2, default 2, meaning write-buffer depth 2**WB_LOG2 entries.
REQ-005 SHALL have port CLK, input, 1, the single clock; all state on rising edge.
REQ-006 SHALL have port RST, input, 1, reset, asynchronous and active-high.
REQ-007 SHALL have ports RE (input, 1, read request) and R_ADR (input, A_W, read address).
REQ-008 SHALL have ports WE (input, 1, write request), W_ADR (input, A_W, write address) and W_DATA (input, D_W, write data).
REQ-009 SHALL have port W_READY, output, 1: buffer can accept a write this cycle.
REQ-010 SHALL have ports EN (output, NB, per-bank enable), WEN (output, NB, per-bank write enable), A (output, NB*BA_W, per-bank address, bank k at slice k) and D (output, NB*D_W, per-bank write data).
REQ-011 SHALL have port R_SEL, output, NB_LOG2: bank of the read issued in the previous cycle, for the read-data mux.
REQ-012 SHALL have ports R_HAZ (output, 1: current read address matches a pending buffered write) and OVF (output, 1: sticky, write dropped while full).

Function
REQ-013 SHALL decode the bank as ADR[NB_LOG2-1:0] and the in-bank address as ADR[A_W-1:NB_LOG2].
REQ-014 SHALL serve a read in the same cycle it is requested: EN[rb]=1, WEN[rb]=0, A[rb]=R_ADR upper bits; reads are never stalled.
REQ-015 SHALL retire writes strictly in arrival order through a FIFO write buffer.
REQ-016 SHALL issue an incoming write directly (bypass) only when the buffer is empty and the write bank differs from the bank of any same-cycle read.
REQ-017 SHALL enqueue any other accepted write {bank, in-bank address, data}.
REQ-018 SHALL drain the buffer head in a cycle when its bank is not used by a same-cycle read, driving EN=1, WEN=1, A and D on that bank, and popping it.
REQ-019 SHALL NOT bypass the incoming write while the buffer is non-empty, even if its bank is free.
REQ-020 SHALL drive W_READY = (count < 2**WB_LOG2), from registered count only; a same-cycle pop SHALL NOT raise it.
REQ-021 SHALL ignore a write with WE=1 and W_READY=0 and set OVF, which SHALL hold until reset.
REQ-022 SHALL support simultaneous push and pop, with the count unchanged; the pointers SHALL wrap modulo depth.
REQ-023 SHALL drive R_HAZ combinationally when RE=1 and R_ADR equals the address of any valid buffer entry; the read SHALL still issue, with stale data.
REQ-024 SHALL hold EN, WEN, A and D at 0 for banks that are idle in a cycle.
REQ-025 SHALL register R_SEL on each cycle with RE=1, and SHALL hold it otherwise.

Reset
REQ-026 SHALL clear, on RST asserted: read/write pointers, count, OVF and R_SEL to 0, and all buffer valid bits; W_READY SHALL then be 1.
REQ-027 SHALL discard buffered writes when reset asserts mid-operation; no bank write SHALL issue while RST=1.

Structure
REQ-028 SHALL take A_W and the D_W default from the shared parameter header (param_define); bank/entry field widths SHALL be localparams.
REQ-029 SHALL implement the buffer as one sub-module, wbuf_fifo (storage, pointers, count, per-entry address-compare outputs); arbitration SHALL stay in bank_sel_buf.

Verification
REQ-030 SHALL cover no conflict: RE with R_ADR=0x10 (bank0) and WE with W_ADR=0x11 (bank1) in the same cycle -> EN=4'b0011, WEN=4'b0010, count stays 0.
REQ-031 SHALL cover conflict: RE with R_ADR=0x04 and WE with W_ADR=0x08 (both bank0) -> the read issues and count=1; on the next cycle with no read -> bank0 EN=1, WEN=1, A=0x02, and count returns to 0.
REQ-032 SHALL cover ordering: with a read held on bank0, write 0x00, 0x01 and 0x02 -> all three are enqueued (no bypass of 0x01 or 0x02); after the read is released they retire one per cycle in order 0x00, 0x01, 0x02.
REQ-033 SHALL cover full/overflow: with depth 4 and a continuous read on bank0, issue five writes to bank0 -> W_READY=0 after the 4th, the 5th is dropped, OVF=1 and sticky.
REQ-034 SHALL cover hazard: a buffered write to 0x0C followed by RE with R_ADR=0x0C -> R_HAZ=1; R_ADR=0x0D -> R_HAZ=0.
REQ-035 SHALL cover reset mid-drain: assert RST with count=3 -> count=0, OVF=0, EN=0 immediately, and no WEN pulse after release.
